snake_food_placer: RTL and testbench
====================================

Name: snake_food_placer

Overview:
Consumes the 7-bit pseudo-random stream from the game's LFSR and turns it into a free grid cell for the next food item. On request it rejects out-of-range samples, checks each candidate against the snake-occupancy memory, and returns the first free cell as X/Y plus linear index. It sits between the LFSR and the game-control FSM; the occupancy lookup port connects to the snake body RAM.

Parameters:
GRID_W, 10, grid width in cells (X range 0..GRID_W-1)
GRID_H, 10, grid height in cells (Y range 0..GRID_H-1); GRID_W*GRID_H must be <= 127
MAX_TRIES, 16, random samples (rejects plus occupied hits) before fallback scan; 1..255

Ports:
i_Clk  in  1  system clock
i_Rst  in  1  asynchronous active-low reset
i_Req  in  1  placement request; sampled only in IDLE
i_RandNum  in  7  LFSR output; advances every cycle; never 0
o_QueryEn  out  1  occupancy lookup strobe
o_QueryIdx  out  7  cell index being looked up
i_Occupied  in  1  lookup result; valid the cycle after o_QueryEn
o_FoodIdx  out  7  placed cell index = Y*GRID_W + X
o_FoodX  out  4  placed X
o_FoodY  out  4  placed Y
o_Valid  out  1  one-cycle pulse: new food outputs valid
o_Fail  out  1  one-cycle pulse: no free cell (fallback build only)
o_Busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, i_Rst=0): state IDLE; all outputs 0; try counter and scan counter 0.
- Candidate mapping: cand = i_RandNum - 1 (range 0..126, so cell 0 is reachable); cand >= GRID_W*GRID_H is a reject.
- States: IDLE, SAMPLE, QUERY, WAIT, DONE, SCAN, FAIL.
- IDLE: i_Req=1 -> SAMPLE, try counter cleared. i_Req in any other state is ignored; it is not queued.
- SAMPLE: latch cand. If in range -> QUERY, else try+1 and stay in SAMPLE, taking the next LFSR value the following cycle.
- QUERY: o_QueryEn=1, o_QueryIdx=cand (Moore outputs) -> WAIT.
- WAIT: i_Occupied=0 -> DONE. i_Occupied=1 -> try+1 and go to SAMPLE.
- Try limit: when try reaches MAX_TRIES, SAMPLE/WAIT take the fallback path (see Optional Feature).
- DONE: o_Valid=1; o_FoodIdx/X/Y register cand at DONE entry -> IDLE. Food outputs hold until the next DONE.
- X/Y split: X = cand mod GRID_W, Y = cand / GRID_W, computed with constant-divisor logic and registered.
- Minimum latency: o_Valid high in the 4th cycle after the cycle that sampled i_Req.
- Reset mid-operation aborts with no o_Valid and no o_Fail pulse.
- o_QueryEn is never high outside QUERY/SCAN.

Optional Feature:
SNAKE_FOOD_SCAN_FALLBACK_EN.
- Defined: on try==MAX_TRIES go to SCAN.
  - SCAN alternates query/wait cycles, stepping cand = (cand+1) mod (GRID_W*GRID_H) from the last candidate (0 if the last was out of range).
  - First free cell -> DONE.
  - After GRID_W*GRID_H consecutive occupied cells -> FAIL: o_Fail=1 for one cycle -> IDLE; food outputs unchanged.
- Undefined: the try counter saturates and random sampling continues indefinitely. SCAN/FAIL logic is absent and o_Fail is tied 0.

Decomposition:
- Shared package snake_pkg:
  - grid constants GRID_W, GRID_H, CELLS
  - index/coordinate widths
  - FSM state encoding localparams (shared with the game-control FSM for debug)
- One natural sub-module, snake_idx_to_xy: combinational index -> X/Y conversion, reused by the renderer.

Test Plan:
- Basic placement: bench drives i_RandNum=24, i_Occupied=0 -> one query at idx 23; o_Valid 4 cycles after i_Req; Idx=23, X=3, Y=2.
- Reject path: i_RandNum=120, 110, then 6 -> two reject cycles, single query at idx 5; o_Valid at cycle 6; X=5, Y=0.
- Occupied retry: idx 23 occupied, then i_RandNum=1 free -> two queries (23 then 0); result Idx=0, X=0, Y=0.
- Fallback scan (macro defined): MAX_TRIES=4, all random candidates occupied, only idx 57 free -> SCAN wraps 99->0 if needed; o_Valid with Idx=57, X=7, Y=5.
  - Variant with all 100 cells occupied -> o_Fail single pulse, o_Valid never, outputs unchanged.
- Reset/ignore: i_Req held high while Busy is ignored (one result per accepted request); i_Rst low during WAIT -> all outputs 0, returns to IDLE, no pulses.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared grid constants, widths and FSM state encoding for the snake food placer
// (also referenced by the game-control FSM for debug).
package snake_pkg;

  localparam int GRID_W = 10;
  localparam int GRID_H = 10;
  localparam int CELLS  = GRID_W * GRID_H;
  localparam int IDX_W  = 7;
  localparam int XY_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SAMPLE = 3'd1,
    ST_QUERY  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DONE   = 3'd4,
    ST_SCAN   = 3'd5,
    ST_FAIL   = 3'd6
  } place_state_e;

  // Linear successor of a cell index, wrapping at the grid size.
  function automatic logic [IDX_W-1:0] next_cell(input logic [IDX_W-1:0] idx,
                                                 input logic [IDX_W-1:0] cells);
    if (idx == cells - 7'd1) begin
      next_cell = 7'd0;
    end else begin
      next_cell = idx + 7'd1;
    end
  endfunction

endpackage

// File: rtl/snake_idx_to_xy.sv
// Combinational linear cell index -> X/Y split (constant divisor); shared with the renderer.
module snake_idx_to_xy #(
  parameter int GRID_W = snake_pkg::GRID_W
) (
  input  logic [6:0] idx,
  output logic [3:0] x,
  output logic [3:0] y
);

  localparam logic [6:0] GRID_W_C = 7'(GRID_W);

  assign x = 4'(idx % GRID_W_C);
  assign y = 4'(idx / GRID_W_C);

endmodule

// File: rtl/snake_food_placer.sv
// Rejection-samples LFSR values into a free grid cell for the next food item.
// Define SNAKE_FOOD_SCAN_FALLBACK_EN to add a linear scan (and o_Fail) after MAX_TRIES misses.
module snake_food_placer #(
  parameter int GRID_W    = 10,
  parameter int GRID_H    = 10,
  parameter int MAX_TRIES = 16
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Req,
  input  logic [6:0] i_RandNum,
  output logic       o_QueryEn,
  output logic [6:0] o_QueryIdx,
  input  logic       i_Occupied,
  output logic [6:0] o_FoodIdx,
  output logic [3:0] o_FoodX,
  output logic [3:0] o_FoodY,
  output logic       o_Valid,
  output logic       o_Fail,
  output logic       o_Busy
);
  import snake_pkg::*;

  localparam logic [6:0] CELLS_C   = 7'(GRID_W * GRID_H);
  localparam logic [7:0] TRY_MAX_C = 8'(MAX_TRIES);

  place_state_e state_r, state_s;
  logic [7:0]   try_r, try_s, try_inc_s;
  logic [6:0]   cand_r, cand_s, rand_cand_s;
  logic         rand_ok_s;
  logic         query_en_s;
  logic [3:0]   cand_x_s, cand_y_s;
  logic         query_en_r, valid_r, busy_r;
  logic [6:0]   query_idx_r, food_idx_r;
  logic [3:0]   food_x_r, food_y_r;
`ifdef SNAKE_FOOD_SCAN_FALLBACK_EN
  logic [6:0]   scan_cnt_r, scan_cnt_s;
  logic         scan_phase_r, scan_phase_s;
  logic         fail_r;
`endif

  // LFSR never emits 0, so subtracting one makes cell 0 reachable.
  assign rand_cand_s = i_RandNum - 7'd1;
  assign rand_ok_s   = (rand_cand_s < CELLS_C);
  assign try_inc_s   = (try_r == TRY_MAX_C) ? try_r : try_r + 8'd1;

  snake_idx_to_xy #(.GRID_W(GRID_W)) u_idx_to_xy (
    .idx (cand_r),
    .x   (cand_x_s),
    .y   (cand_y_s)
  );

  // Next-state, try/scan counters and candidate selection.
  always_comb begin
    state_s = state_r;
    try_s   = try_r;
    cand_s  = cand_r;
`ifdef SNAKE_FOOD_SCAN_FALLBACK_EN
    scan_cnt_s   = scan_cnt_r;
    scan_phase_s = scan_phase_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (i_Req) begin
          state_s = ST_SAMPLE;
          try_s   = 8'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SAMPLE: begin
        cand_s = rand_cand_s;
        if (rand_ok_s) begin
          state_s = ST_QUERY;
        end else begin
          try_s = try_inc_s;
`ifdef SNAKE_FOOD_SCAN_FALLBACK_EN
          if (try_inc_s == TRY_MAX_C) begin
            state_s      = ST_SCAN;
            cand_s       = 7'd0;
            scan_cnt_s   = 7'd0;
            scan_phase_s = 1'b0;
          end else begin
            state_s = ST_SAMPLE;
          end
`else
          state_s = ST_SAMPLE;
`endif
        end
      end
      ST_QUERY: state_s = ST_WAIT;
      ST_WAIT: begin
        if (!i_Occupied) begin
          state_s = ST_DONE;
        end else begin
          try_s = try_inc_s;
`ifdef SNAKE_FOOD_SCAN_FALLBACK_EN
          if (try_inc_s == TRY_MAX_C) begin
            state_s      = ST_SCAN;
            cand_s       = next_cell(cand_r, CELLS_C);
            scan_cnt_s   = 7'd0;
            scan_phase_s = 1'b0;
          end else begin
            state_s = ST_SAMPLE;
          end
`else
          state_s = ST_SAMPLE;
`endif
        end
      end
      ST_DONE: state_s = ST_IDLE;
`ifdef SNAKE_FOOD_SCAN_FALLBACK_EN
      // Phase 0 issues the lookup, phase 1 consumes its result.
      ST_SCAN: begin
        if (!scan_phase_r) begin
          scan_phase_s = 1'b1;
        end else if (!i_Occupied) begin
          state_s = ST_DONE;
        end else if (scan_cnt_r == CELLS_C - 7'd1) begin
          state_s = ST_FAIL;
        end else begin
          scan_cnt_s   = scan_cnt_r + 7'd1;
          cand_s       = next_cell(cand_r, CELLS_C);
          scan_phase_s = 1'b0;
        end
      end
      ST_FAIL: state_s = ST_IDLE;
`endif
      default: state_s = ST_IDLE;
    endcase
  end

`ifdef SNAKE_FOOD_SCAN_FALLBACK_EN
  assign query_en_s = (state_s == ST_QUERY) || ((state_s == ST_SCAN) && !scan_phase_s);
`else
  assign query_en_s = (state_s == ST_QUERY);
`endif

  // FSM state and counter registers.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_r <= ST_IDLE;
      try_r   <= 8'd0;
      cand_r  <= 7'd0;
`ifdef SNAKE_FOOD_SCAN_FALLBACK_EN
      scan_cnt_r   <= 7'd0;
      scan_phase_r <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      try_r   <= try_s;
      cand_r  <= cand_s;
`ifdef SNAKE_FOOD_SCAN_FALLBACK_EN
      scan_cnt_r   <= scan_cnt_s;
      scan_phase_r <= scan_phase_s;
`endif
    end
  end

  // Registered outputs decoded from the upcoming state; food registers load on DONE entry.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      query_en_r  <= 1'b0;
      query_idx_r <= 7'd0;
      valid_r     <= 1'b0;
      busy_r      <= 1'b0;
      food_idx_r  <= 7'd0;
      food_x_r    <= 4'd0;
      food_y_r    <= 4'd0;
`ifdef SNAKE_FOOD_SCAN_FALLBACK_EN
      fail_r      <= 1'b0;
`endif
    end else begin
      query_en_r <= query_en_s;
      valid_r    <= (state_s == ST_DONE);
      busy_r     <= (state_s != ST_IDLE);
`ifdef SNAKE_FOOD_SCAN_FALLBACK_EN
      fail_r     <= (state_s == ST_FAIL);
`endif
      if (query_en_s) begin
        query_idx_r <= cand_s;
      end else begin
        query_idx_r <= query_idx_r;
      end
      if (state_s == ST_DONE) begin
        food_idx_r <= cand_r;
        food_x_r   <= cand_x_s;
        food_y_r   <= cand_y_s;
      end else begin
        food_idx_r <= food_idx_r;
        food_x_r   <= food_x_r;
        food_y_r   <= food_y_r;
      end
    end
  end

  assign o_QueryEn  = query_en_r;
  assign o_QueryIdx = query_idx_r;
  assign o_Valid    = valid_r;
  assign o_Busy     = busy_r;
  assign o_FoodIdx  = food_idx_r;
  assign o_FoodX    = food_x_r;
  assign o_FoodY    = food_y_r;
`ifdef SNAKE_FOOD_SCAN_FALLBACK_EN
  assign o_Fail     = fail_r;
`else
  assign o_Fail     = 1'b0;
`endif

endmodule

// File: tb/tb_snake_food_placer.sv
// Self-checking bench for snake_food_placer: directed and random placements against a rule-level model.
module tb_snake_food_placer;

  localparam int GW    = 10;
  localparam int GH    = 10;
  localparam int CELLS = GW * GH;
  localparam int MAX_T = 4;
  localparam int SEQ_N = 1024;

  logic       i_Clk, i_Rst, i_Req, i_Occupied;
  logic [6:0] i_RandNum;
  logic       o_QueryEn, o_Valid, o_Fail, o_Busy;
  logic [6:0] o_QueryIdx, o_FoodIdx;
  logic [3:0] o_FoodX, o_FoodY;

  logic [6:0] rand_seq [0:SEQ_N-1];
  bit         occ [0:127];
  int         exp_q [$];
  int         total, bad;
  int         exp_food_idx;

  snake_food_placer #(.GRID_W(GW), .GRID_H(GH), .MAX_TRIES(MAX_T)) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Req(i_Req), .i_RandNum(i_RandNum),
    .o_QueryEn(o_QueryEn), .o_QueryIdx(o_QueryIdx), .i_Occupied(i_Occupied),
    .o_FoodIdx(o_FoodIdx), .o_FoodX(o_FoodX), .o_FoodY(o_FoodY),
    .o_Valid(o_Valid), .o_Fail(o_Fail), .o_Busy(o_Busy)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_qen"},  int'(o_QueryEn), 0);
    check({tag, "_qidx"}, int'(o_QueryIdx), 0);
    check({tag, "_fidx"}, int'(o_FoodIdx), 0);
    check({tag, "_fx"},   int'(o_FoodX), 0);
    check({tag, "_fy"},   int'(o_FoodY), 0);
    check({tag, "_pulse"}, int'(o_Valid) + int'(o_Fail), 0);
    check({tag, "_busy"}, int'(o_Busy), 0);
  endtask

  task automatic fill_seq(input int v);
    for (int i = 0; i < SEQ_N; i++) rand_seq[i] = 7'(v);
  endtask

  task automatic fill_occ(input bit v);
    for (int i = 0; i < 128; i++) occ[i] = v;
  endtask

  // Rule-level model: cycle k after the request cycle presents rand_seq[k].
  function automatic void model(output int r_idx, output int lat, output int nq, output bit fail);
    int t, tries, c, s, ts;
    bit scan;
    t = 1; tries = 0; nq = 0; fail = 1'b0; r_idx = -1; lat = -1; scan = 1'b0; s = 0; ts = 0;
    exp_q.delete();
    while (t < SEQ_N - 4 && !scan) begin
      c = int'(rand_seq[t]) - 1;
      if (c >= CELLS) begin
        tries++;
`ifdef SNAKE_FOOD_SCAN_FALLBACK_EN
        if (tries >= MAX_T) begin scan = 1'b1; s = 0; ts = t + 1; end
`endif
        t = t + 1;
      end else begin
        nq++;
        exp_q.push_back(c);
        if (!occ[c]) begin r_idx = c; lat = t + 3; return; end
        tries++;
`ifdef SNAKE_FOOD_SCAN_FALLBACK_EN
        if (tries >= MAX_T) begin scan = 1'b1; s = (c + 1) % CELLS; ts = t + 3; end
`endif
        t = t + 3;
      end
    end
    if (scan) begin
      for (int k = 0; k < CELLS; k++) begin
        c = (s + k) % CELLS;
        nq++;
        exp_q.push_back(c);
        if (!occ[c]) begin r_idx = c; lat = ts + 2 * k + 2; return; end
      end
      fail = 1'b1;
      lat = ts + 2 * CELLS;
    end
  endfunction

  // Issue one request from an IDLE cycle, answer lookups from occ[], compare with the model.
  task automatic run_req(input string tag, input bit hold_req);
    int m_idx, m_lat, m_nq, nq, qbad, busy_low, v_cyc, f_cyc, got_idx, got_x, got_y;
    bit m_fail, done, prev_qen;
    logic [6:0] prev_qidx;
    model(m_idx, m_lat, m_nq, m_fail);
    nq = 0; qbad = 0; busy_low = 0; v_cyc = -1; f_cyc = -1;
    got_idx = -1; got_x = -1; got_y = -1; done = 1'b0; prev_qen = 1'b0; prev_qidx = 7'd0;
    i_Req = 1'b1; i_RandNum = rand_seq[0]; i_Occupied = 1'b0;
    for (int k = 1; k <= 700 && !done; k++) begin
      @(posedge i_Clk); #1;
      if (!hold_req) i_Req = 1'b0;
      i_RandNum  = rand_seq[k];
      i_Occupied = prev_qen ? occ[prev_qidx] : 1'b0;
      prev_qen   = o_QueryEn;
      prev_qidx  = o_QueryIdx;
      if (o_QueryEn) begin
        nq++;
        if (exp_q.size() == 0) qbad++;
        else if (int'(o_QueryIdx) != exp_q.pop_front()) qbad++;
      end
      if (!o_Busy) busy_low++;
      if (o_Valid || o_Fail) begin
        done = 1'b1;
        i_Req = 1'b0;
        if (o_Valid) v_cyc = k;
        if (o_Fail) f_cyc = k;
        got_idx = int'(o_FoodIdx); got_x = int'(o_FoodX); got_y = int'(o_FoodY);
      end
    end
    check({tag, "_done"}, int'(done), 1);
    if (m_fail) begin
      check({tag, "_fail_cyc"}, f_cyc, m_lat);
      check({tag, "_no_valid"}, v_cyc, -1);
    end else begin
      check({tag, "_valid_cyc"}, v_cyc, m_lat);
      check({tag, "_no_fail"}, f_cyc, -1);
      exp_food_idx = m_idx;
    end
    check({tag, "_idx"}, got_idx, exp_food_idx);
    check({tag, "_x"}, got_x, exp_food_idx % GW);
    check({tag, "_y"}, got_y, exp_food_idx / GW);
    check({tag, "_nquery"}, nq, m_nq);
    check({tag, "_qidx_bad"}, qbad, 0);
    check({tag, "_busy_low"}, busy_low, 0);
    @(posedge i_Clk); #1;
    i_Occupied = 1'b0;
    check({tag, "_post_pulse"}, int'(o_Valid) + int'(o_Fail), 0);
    check({tag, "_post_busy"}, int'(o_Busy), 0);
  endtask

  initial begin
    int pulses;
    total = 0; bad = 0; exp_food_idx = 0;
    i_Rst = 1'b0; i_Req = 1'b0; i_RandNum = 7'd1; i_Occupied = 1'b0;
    fill_seq(127); fill_occ(1'b0);
    repeat (2) @(posedge i_Clk);
    #1;
    check_zero("reset");
    i_Rst = 1'b1;
    @(posedge i_Clk); #1;

    // Basic placement: 24 -> cell 23 at (3,2), valid four cycles after the request.
    fill_seq(127); fill_occ(1'b0); rand_seq[1] = 7'd24;
    run_req("basic", 1'b0);
    check("basic_idx_const", int'(o_FoodIdx), 23);
    check("basic_xy_const", int'(o_FoodX) * 16 + int'(o_FoodY), 3 * 16 + 2);

    // Two rejects then 6 -> cell 5.
    fill_seq(127); rand_seq[1] = 7'd120; rand_seq[2] = 7'd110; rand_seq[3] = 7'd6;
    run_req("reject", 1'b0);
    check("reject_idx_const", int'(o_FoodIdx), 5);

    // Occupied retry: 23 busy, then 1 -> cell 0.
    fill_seq(127); occ[23] = 1'b1; rand_seq[1] = 7'd24; rand_seq[4] = 7'd1;
    run_req("retry", 1'b0);
    check("retry_idx_const", int'(o_FoodIdx), 0);

`ifdef SNAKE_FOOD_SCAN_FALLBACK_EN
    fill_occ(1'b1); occ[57] = 1'b0;
    for (int i = 0; i < SEQ_N; i++) rand_seq[i] = 7'($urandom_range(1, 127));
    run_req("scan57", 1'b0);
    check("scan57_idx_const", int'(o_FoodIdx), 57);
    check("scan57_xy_const", int'(o_FoodX) * 16 + int'(o_FoodY), 7 * 16 + 5);
    fill_occ(1'b1);
    run_req("scanfull", 1'b0);
    check("scanfull_kept", int'(o_FoodIdx), 57);
`else
    // Try counter saturates; random sampling keeps going until cell 57 is drawn.
    fill_occ(1'b1); occ[57] = 1'b0; fill_seq(127);
    rand_seq[1] = 7'd24; rand_seq[40] = 7'd58;
    run_req("saturate", 1'b0);
    check("saturate_idx_const", int'(o_FoodIdx), 57);
`endif

    // Request held high throughout: only one placement per accepted request.
    fill_occ(1'b0); occ[40] = 1'b1; fill_seq(127); rand_seq[1] = 7'd41; rand_seq[4] = 7'd100;
    run_req("hold", 1'b1);
    repeat (3) begin
      @(posedge i_Clk); #1;
      check("hold_idle_busy", int'(o_Busy), 0);
    end

    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < CELLS; i++) occ[i] = ($urandom_range(0, 1) == 1);
      for (int i = 0; i < SEQ_N; i++) rand_seq[i] = 7'($urandom_range(1, 127));
      run_req($sformatf("rand%0d", r), 1'b0);
    end

    // Reset asserted during WAIT aborts without pulses.
    fill_occ(1'b0); fill_seq(127); rand_seq[1] = 7'd24;
    i_Req = 1'b1; i_RandNum = rand_seq[0];
    for (int k = 1; k <= 3; k++) begin
      @(posedge i_Clk); #1;
      i_Req = 1'b0; i_RandNum = rand_seq[k];
    end
    check("rst_wait_busy", int'(o_Busy), 1);
    #2 i_Rst = 1'b0;
    #1;
    check_zero("rst_async");
    @(posedge i_Clk); #1;
    i_Rst = 1'b1;
    exp_food_idx = 0;
    pulses = 0;
    repeat (6) begin
      @(posedge i_Clk); #1;
      pulses += int'(o_Valid) + int'(o_Fail) + int'(o_Busy);
    end
    check("rst_after_quiet", pulses, 0);

    fill_seq(127); rand_seq[1] = 7'd100;
    run_req("after_rst", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
